// File: rtl/regseq_pkg.sv
// Shared types and sizing for the regfile sequencer and the 8x16 register file.
package regseq_pkg;

  localparam int REGSEQ_DW = 16;
  localparam int REGSEQ_AW = 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    RSP  = 3'd3,
    WR   = 3'd4
  } regseq_state_e;

  typedef enum logic {
    OP_READ2 = 1'b0,
    OP_WRITE = 1'b1
  } regseq_op_e;

endpackage

// File: rtl/regfile.sv
// 8x16 register file: one combinational read port, one clocked write port.
module regfile
  import regseq_pkg::*;
#(
  parameter int DW = REGSEQ_DW,
  parameter int AW = REGSEQ_AW
) (
  input  logic          clk,
  input  logic          write,
  input  logic [AW-1:0] writenum,
  input  logic [AW-1:0] readnum,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out
);

  logic [DW-1:0] regs [2**AW];

  // Commit the write port on the rising edge.
  // NOTE: storage arrays carry no reset; contents are defined by the writes that
  // software performs, and a reset branch would keep this from mapping to RAM.
  always_ff @(posedge clk) begin
    if (write) regs[writenum] <= data_in;
  end

  assign data_out = regs[readnum];

endmodule

// File: rtl/regfile_sequencer.sv
// Initiator for the regfile port: accepts READ2/WRITE requests over valid/ready,
// sequences the single read port twice for READ2, issues a one-cycle write for
// WRITE, and returns operands A/B over a valid/ready response channel.
// Build option: define REGSEQ_DUP_SKIP_EN to skip the second read when rn == rm.
module regfile_sequencer
  import regseq_pkg::*;
#(
  parameter int DW = REGSEQ_DW,
  parameter int AW = REGSEQ_AW
) (
  input  logic          clk,
  input  logic          reset_n,
  // request channel
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_op,
  input  logic [AW-1:0] req_rn,
  input  logic [AW-1:0] req_rm,
  input  logic [AW-1:0] req_rd,
  input  logic [DW-1:0] req_wdata,
  // response channel
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_a,
  output logic [DW-1:0] rsp_b,
  // register file port
  output logic [AW-1:0] rf_readnum,
  output logic [AW-1:0] rf_writenum,
  output logic          rf_write,
  output logic [DW-1:0] rf_data_in,
  input  logic [DW-1:0] rf_data_out
);

  regseq_state_e state;
  regseq_op_e    op_q;
  logic [AW-1:0] rn_q;
  logic [AW-1:0] rm_q;
  logic [AW-1:0] rd_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;

  // FSM plus request/operand capture; everything returns to IDLE on reset.
  // NOTE: all state here uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order within the block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      op_q    <= OP_READ2;
      rn_q    <= '0;
      rm_q    <= '0;
      rd_q    <= '0;
      wdata_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q    <= regseq_op_e'(req_op);
            rn_q    <= req_rn;
            rm_q    <= req_rm;
            rd_q    <= req_rd;
            wdata_q <= req_wdata;
            state   <= (regseq_op_e'(req_op) == OP_WRITE) ? WR : RD_A;
          end
        end
        RD_A: begin
          a_q <= rf_data_out;
`ifdef REGSEQ_DUP_SKIP_EN
          // Same index twice: the value just read is operand B as well.
          if (rn_q == rm_q) begin
            b_q   <= rf_data_out;
            state <= RSP;
          end else begin
            state <= RD_B;
          end
`else
          state <= RD_B;
`endif
        end
        RD_B: begin
          b_q   <= rf_data_out;
          state <= RSP;
        end
        RSP: begin
          if (rsp_ready) state <= IDLE;
        end
        WR: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode straight from the state register.
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RSP) && (op_q == OP_READ2);
  assign rsp_a     = a_q;
  assign rsp_b     = b_q;

  // Register-file port: read index only while reading, write strobe only in WR.
  // Because these decode from the async-reset state, rf_write drops the moment
  // reset_n falls, so a write in flight never reaches the array.
  assign rf_readnum  = (state == RD_A) ? rn_q :
                       (state == RD_B) ? rm_q : '0;
  assign rf_write    = (state == WR) && (op_q == OP_WRITE);
  assign rf_writenum = rf_write ? rd_q    : '0;
  assign rf_data_in  = rf_write ? wdata_q : '0;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Testbench for regfile_sequencer driving a real regfile. Expected responses are
// queued at issue time and compared by a monitor when the response handshakes.
module tb_regfile_sequencer;
  import regseq_pkg::*;

  localparam int DW = REGSEQ_DW;
  localparam int AW = REGSEQ_AW;
`ifdef REGSEQ_DUP_SKIP_EN
  localparam int DUP_LAT = 2;
`else
  localparam int DUP_LAT = 3;
`endif

  logic          clk;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_op;
  logic [AW-1:0] req_rn;
  logic [AW-1:0] req_rm;
  logic [AW-1:0] req_rd;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_a;
  logic [DW-1:0] rsp_b;
  logic [AW-1:0] rf_readnum;
  logic [AW-1:0] rf_writenum;
  logic          rf_write;
  logic [DW-1:0] rf_data_in;
  logic [DW-1:0] rf_data_out;

  regfile_sequencer #(.DW(DW), .AW(AW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_rn      (req_rn),
    .req_rm      (req_rm),
    .req_rd      (req_rd),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_a       (rsp_a),
    .rsp_b       (rsp_b),
    .rf_readnum  (rf_readnum),
    .rf_writenum (rf_writenum),
    .rf_write    (rf_write),
    .rf_data_in  (rf_data_in),
    .rf_data_out (rf_data_out)
  );

  regfile #(.DW(DW), .AW(AW)) u_rf (
    .clk      (clk),
    .write    (rf_write),
    .writenum (rf_writenum),
    .readnum  (rf_readnum),
    .data_in  (rf_data_in),
    .data_out (rf_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } rsp_t;
  rsp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor: pops one expected response per handshake.
  rsp_t mon_e;
  always @(negedge clk) begin
    if (reset_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", exp_q.size(), 1);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_a", rsp_a, mon_e.a);
        check("rsp_b", rsp_b, mon_e.b);
      end
    end
  end

  // Wait (bounded) for req_ready at a falling edge, present the request there,
  // and return just after the accepting rising edge.
  task automatic issue(input logic op, input logic [AW-1:0] rn, input logic [AW-1:0] rm,
                       input logic [AW-1:0] rd, input logic [DW-1:0] wd);
    bit seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        seen = 1;
        break;
      end
    end
    check("req_ready_wait", 32'(seen), 1);
    req_op    = op;
    req_rn    = rn;
    req_rm    = rm;
    req_rd    = rd;
    req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Count cycles after acceptance until rsp_valid; cycle 1 is the RD_A cycle.
  task automatic wait_rsp(input logic [AW-1:0] rn, input int exp_lat,
                          output logic [DW-1:0] a, output logic [DW-1:0] b);
    int lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) check("rd_a_index", 32'(rf_readnum), 32'(rn));
      if (rsp_valid) begin
        lat = i;
        break;
      end
    end
    check("rsp_latency", lat, exp_lat);
    a = rsp_a;
    b = rsp_b;
  endtask

  task automatic do_write(input logic [AW-1:0] rd, input logic [DW-1:0] wd);
    issue(1'b1, '0, '0, rd, wd);
    @(negedge clk);
    check("wr_strobe",   32'(rf_write), 1);
    check("wr_index",    32'(rf_writenum), 32'(rd));
    check("wr_data",     32'(rf_data_in), 32'(wd));
    check("wr_busy",     32'(req_ready), 0);
    @(negedge clk);
    check("wr_one_cycle", 32'(rf_write), 0);
    check("wr_done_rdy",  32'(req_ready), 1);
  endtask

  task automatic do_read(input logic [AW-1:0] rn, input logic [AW-1:0] rm,
                         input logic [DW-1:0] ea, input logic [DW-1:0] eb, input int exp_lat);
    logic [DW-1:0] a, b;
    exp_q.push_back('{a: ea, b: eb});
    issue(1'b0, rn, rm, '0, '0);
    wait_rsp(rn, exp_lat, a, b);
    @(negedge clk);
    check("rd_back_idle", 32'(req_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] a0, b0;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_op    = 1'b0;
    req_rn    = '0;
    req_rm    = '0;
    req_rd    = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;

    // 1. Reset state.
    #2;
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rf_write",  32'(rf_write), 0);
    check("rst_rsp_a",     32'(rsp_a), 0);
    check("rst_rsp_b",     32'(rsp_b), 0);
    check("rst_readnum",   32'(rf_readnum), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    // Known contents for the registers used below.
    do_write(3'd0, 16'h0F0F);
    do_write(3'd1, 16'h1111);
    do_write(3'd2, 16'h2222);
    do_write(3'd5, 16'h0042);
    do_write(3'd7, 16'h7777);

    // 2. WRITE then READ2 of the new value.
    do_write(3'd3, 16'hBEEF);
    do_read(3'd3, 3'd0, 16'hBEEF, 16'h0F0F, 3);

    // 3. Backpressure: hold rsp_ready low for 5 cycles.
    rsp_ready = 1'b0;
    exp_q.push_back('{a: 16'h1111, b: 16'h2222});
    issue(1'b0, 3'd1, 3'd2, '0, '0);
    wait_rsp(3'd1, 3, a0, b0);
    repeat (5) begin
      @(negedge clk);
      check("bp_valid",  32'(rsp_valid), 1);
      check("bp_a_hold", 32'(rsp_a), 32'(a0));
      check("bp_b_hold", 32'(rsp_b), 32'(b0));
      check("bp_busy",   32'(req_ready), 0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_valid", 32'(rsp_valid), 0);
    check("bp_release_ready", 32'(req_ready), 1);

    // 4. Duplicate index read.
    do_read(3'd5, 3'd5, 16'h0042, 16'h0042, DUP_LAT);

    // 5. Reset during WR: the pending write to R7 must be lost.
    issue(1'b1, '0, '0, 3'd7, 16'h1234);
    @(negedge clk);
    check("mid_wr_strobe", 32'(rf_write), 1);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_write", 32'(rf_write), 0);
    check("mid_rst_ready", 32'(req_ready), 1);
    check("mid_rst_wnum",  32'(rf_writenum), 0);
    @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    do_read(3'd7, 3'd7, 16'h7777, 16'h7777, DUP_LAT);

    // 6. Back-to-back: READ2 held valid behind a WRITE to the same register.
    issue(1'b1, '0, '0, 3'd2, 16'h00AA);
    req_op    = 1'b0;
    req_rn    = 3'd2;
    req_rm    = 3'd2;
    req_valid = 1'b1;
    exp_q.push_back('{a: 16'h00AA, b: 16'h00AA});
    @(negedge clk);
    check("b2b_wr_busy",   32'(req_ready), 0);
    check("b2b_wr_strobe", 32'(rf_write), 1);
    @(negedge clk);
    check("b2b_rd_ready",  32'(req_ready), 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp(3'd2, DUP_LAT, a0, b0);
    @(negedge clk);
    check("b2b_back_idle", 32'(req_ready), 1);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
